// File: rtl/rotary_decoder.sv
// Quadrature rotary decoder: synchronizes and debounces the A/B channels,
// decodes Gray-code transitions into counted steps at x1/x2/x4 resolution
// and maintains a wrapping or saturating position count with a sticky
// illegal-transition flag.
module rotary_decoder #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic [1:0]       mode,
    input  logic             sat_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_err,
    output logic [WIDTH-1:0] value,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    // Channel index 1 is A, index 0 is B, so packed pairs read as {A,B}.
    logic [1:0]                  raw_c;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  filt_q, filt_d;
    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  prev_q;
    logic [WIDTH-1:0]            value_q, value_d;
    logic                        dir_q, dir_d;
    logic                        step_q, step_d;
    logic                        err_q, err_d;

    logic fwd_c, bwd_c, illegal_c, count_en_c;

    assign raw_c = {a, b};

    // Debounce: the filtered level follows the synced level only after it has
    // disagreed for FILTER_CYCLES consecutive clocks.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync_q[ch][SYNC_STAGES-1] != filt_q[ch]) begin
                if (cnt_q[ch] == CNT_W'(FILTER_CYCLES - 1)) begin
                    filt_d[ch] = sync_q[ch][SYNC_STAGES-1];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Classify the prev -> current filtered pair on the 00-10-11-01 Gray cycle.
    always_comb begin
        fwd_c     = 1'b0;
        bwd_c     = 1'b0;
        illegal_c = 1'b0;
        unique case ({prev_q, filt_q})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd_c     = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: bwd_c     = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal_c = 1'b1;
            default: ;
        endcase
    end

    // Resolution gate: x1 counts only the 00<->10 edge, x2 only A edges.
    always_comb begin
        count_en_c = 1'b1;
        case (mode)
            2'b00:   count_en_c = (fwd_c && (prev_q == 2'b00)) ||
                                  (bwd_c && (prev_q == 2'b10));
            2'b01:   count_en_c = prev_q[1] ^ filt_q[1];
            default: count_en_c = 1'b1;
        endcase
    end

    // Position, direction, step pulse and sticky error next-state.
    always_comb begin
        value_d = value_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;

        if (clear_err) begin
            err_d = 1'b0;
        end
        if (illegal_c) begin
            err_d = 1'b1;
        end

        if (load) begin
            value_d = load_value;
        end else if (fwd_c && count_en_c) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            if (!(sat_en && (value_q == MAX_VAL))) begin
                value_d = value_q + WIDTH'(1);
            end
        end else if (bwd_c && count_en_c) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            if (!(sat_en && (value_q == '0))) begin
                value_d = value_q - WIDTH'(1);
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            value_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw_c[ch]};
            end
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            prev_q  <= filt_q;
            value_q <= value_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign value = value_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter WIDTH, default 8: width of position counter value.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: synchronizer flops per quadrature input.
REQ-003 Parameter FILTER_CYCLES, default 4, minimum 1: consecutive clocks a synced input must disagree with its filtered level before the filtered level updates.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 a, b  input  1 each  raw asynchronous quadrature channels.
REQ-007 mode  input  2  count resolution: 00 = x1, 01 = x2, 10 = x4, 11 = x4.
REQ-008 sat_en  input  1  1 = saturate at 0 / 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_value  input  WIDTH  value written on load.
REQ-011 clear_err  input  1  clears sticky err.
REQ-012 value  output  WIDTH  registered position count.
REQ-013 dir  output  1  registered direction of last counted event (1 = forward).
REQ-014 step  output  1  one-clock pulse per counted event.
REQ-015 err  output  1  sticky illegal-transition flag.

Function
REQ-016 Each of a, b SHALL pass through a SYNC_STAGES flop synchronizer before any other use.
REQ-017 Per channel, a counter SHALL increment while synced level != filtered level and clear when equal; on reaching FILTER_CYCLES the filtered level SHALL take the synced level and the counter SHALL clear.
REQ-018 Registered prev state {A,B} SHALL capture the filtered pair every clock; events SHALL be decoded from prev -> current filtered pair.
REQ-019 Forward sequence (AB) SHALL be 00->10->11->01->00; backward is the reverse.
REQ-020 x4: every forward/backward transition SHALL count; x2: only transitions where A changes; x1: only 00->10 (forward) and 10->00 (backward).
REQ-021 No change SHALL produce no event; a transition changing both A and B SHALL produce no count and SHALL set err.
REQ-022 Counted forward event: value+1, dir<=1, step<=1; backward: value-1, dir<=0, step<=1; otherwise step<=0 and dir holds.
REQ-023 sat_en=0: value wraps (2^WIDTH-1 +1 = 0; 0 -1 = 2^WIDTH-1).
REQ-024 sat_en=1: value holds at 2^WIDTH-1 on forward and at 0 on backward; step and dir still update for the event.
REQ-025 load=1 SHALL set value<=load_value, step<=0, dir holds, overriding any event that cycle; prev and filter state still update.
REQ-026 err SHALL set on illegal transition and stay set until clear_err=1; simultaneous set and clear_err SHALL leave err=1.
REQ-027 Latency: from the first rising edge sampling a new stable raw level, value/step SHALL change on edge SYNC_STAGES+FILTER_CYCLES+1 (7 with defaults).
REQ-028 Changing mode or sat_en SHALL generate no event; new setting applies from the next decoded transition.
REQ-029 Input pulses shorter than FILTER_CYCLES synced clocks SHALL be fully rejected (no event, no err).

Reset
REQ-030 reset=0 SHALL immediately, without clock, force value=0, dir=0, step=0, err=0, all synchronizer flops, filtered levels, filter counters and prev to 0.
REQ-031 Reset asserted mid-sequence SHALL discard all in-flight filtering; after release the first event requires full REQ-027 latency.
REQ-032 Reset release SHALL be synchronized externally; no event SHALL occur on the release edge.

Verification (WIDTH=8, SYNC_STAGES=2, FILTER_CYCLES=4)
REQ-033 mode=10, 4 forward AB cycles, each level held 8 clocks -> value=16, dir=1, exactly 16 step pulses, err=0.
REQ-034 mode=00, sat_en=0, 3 backward cycles from 0 -> value=253, dir=0, 3 step pulses.
REQ-035 sat_en=1, load value 0xFE, 3 forward x4 steps -> value=0xFF, 3 step pulses; load during an event cycle -> value=load_value, step=0.
REQ-036 a high for 3 clocks then low -> no step, value unchanged; AB 00->11 held 8 clocks -> err=1, value unchanged; clear_err -> err=0; clear_err with simultaneous illegal transition -> err=1.
REQ-037 Single a 0->1 edge in x4 with B=0 -> value 0->1 exactly 7 edges after first sampling edge.
REQ-038 reset pulsed low between clock edges mid-sequence with value=5 -> all outputs 0 before next edge; next event after release at full latency.
